// File: rtl/clk_period_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_monitor_pkg
// Description : Shared definitions for the clock-monitor family. Holds the
//               monitor state encodings so future clock-monitor blocks agree
//               on them.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_period_monitor_pkg;

    localparam int c_STATE_W = 2;

    // Monitor states
    localparam logic [c_STATE_W-1:0] c_IDLE   = 2'd0;  // waiting for the first edge
    localparam logic [c_STATE_W-1:0] c_MEAS   = 2'd1;  // measuring, not yet stable
    localparam logic [c_STATE_W-1:0] c_LOCKED = 2'd2;  // period stable
    localparam logic [c_STATE_W-1:0] c_LOST   = 2'd3;  // edges stopped

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Two-flop synchroniser for an asynchronous level, followed by
//               a history flop. Produces single-cycle rise and fall pulses
//               in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // Metastability filter (s1, s2) plus one cycle of history for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= async_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_prev;
    assign fall = ~r_s2 & r_prev;

endmodule
`default_nettype wire

// File: rtl/clk_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_monitor
// Description : Measures the period and high time of a slow asynchronous
//               clock in system-clock cycles, flags lock once the period is
//               stable and flags loss when rising edges stop arriving.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_period_monitor
    import clk_period_monitor_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int TIMEOUT    = 50000,
    parameter int LOCK_COUNT = 4,
    parameter int TOLERANCE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int                   c_MATCH_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0]     c_CNT_MAX   = '1;
    localparam logic [WIDTH-1:0]     c_CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]     c_TIMEOUT   = WIDTH'(TIMEOUT);
    localparam logic [WIDTH:0]       c_TOL       = (WIDTH+1)'(TOLERANCE);
    localparam logic [c_MATCH_W-1:0] c_LOCK      = c_MATCH_W'(LOCK_COUNT);
    localparam logic [c_MATCH_W-1:0] c_MATCH_ONE = c_MATCH_W'(1);

    logic                 w_rise;
    logic                 w_fall;
    logic [WIDTH-1:0]     r_cnt;
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_MATCH_W-1:0] r_match_cnt;
    logic [c_MATCH_W-1:0] w_match_nxt;
    logic [c_MATCH_W-1:0] w_match_cand;
    logic [WIDTH-1:0]     r_period;
    logic [WIDTH-1:0]     w_period_nxt;
    logic [WIDTH-1:0]     r_high;
    logic [WIDTH-1:0]     w_high_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_locked;
    logic                 w_locked_nxt;
    logic                 r_lost;
    logic                 w_lost_nxt;
    logic [WIDTH:0]       w_cnt_x;
    logic [WIDTH:0]       w_per_x;
    logic [WIDTH:0]       w_diff;
    logic                 w_match;

    sync_edge_detect u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (clk_in),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    // Cycles since the last detected rise; restarts at 1 and never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= c_CNT_ONE;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // New period vs previous one, one bit wider so the subtraction cannot wrap
    assign w_cnt_x = {1'b0, r_cnt};
    assign w_per_x = {1'b0, r_period};
    assign w_diff  = (w_cnt_x >= w_per_x) ? (w_cnt_x - w_per_x) : (w_per_x - w_cnt_x);
    assign w_match = (w_diff <= c_TOL);

    // First period after a restart counts as 1; the run holds at LOCK_COUNT
    assign w_match_cand = ((r_match_cnt == '0) || !w_match) ? c_MATCH_ONE :
                          (r_match_cnt == c_LOCK)            ? r_match_cnt :
                                                               r_match_cnt + c_MATCH_ONE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of all reported outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_match_nxt  = r_match_cnt;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_valid_nxt  = 1'b0;
        w_locked_nxt = r_locked;
        w_lost_nxt   = r_lost;
        case (r_state)
            c_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = c_MEAS;
                end
            end
            c_MEAS, c_LOCKED: begin
                if (w_rise) begin
                    w_period_nxt = r_cnt;
                    w_valid_nxt  = 1'b1;
                    w_match_nxt  = w_match_cand;
                    if (w_match_cand == c_LOCK) begin
                        w_state_nxt  = c_LOCKED;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = c_MEAS;
                        w_locked_nxt = 1'b0;
                    end
                end else begin
                    if (w_fall) begin
                        w_high_nxt = r_cnt;
                    end
                    // A rise on the timeout cycle takes the branch above instead
                    if (r_cnt == c_TIMEOUT) begin
                        w_state_nxt  = c_LOST;
                        w_lost_nxt   = 1'b1;
                        w_locked_nxt = 1'b0;
                        w_match_nxt  = '0;
                    end
                end
            end
            c_LOST: begin
                // Recovery edge only restarts timing, like the first edge after reset
                if (w_rise) begin
                    w_state_nxt = c_MEAS;
                    w_lost_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output and match-run registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= '0;
            r_period    <= '0;
            r_high      <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_match_cnt <= w_match_nxt;
            r_period    <= w_period_nxt;
            r_high      <= w_high_nxt;
            r_valid     <= w_valid_nxt;
            r_locked    <= w_locked_nxt;
            r_lost      <= w_lost_nxt;
        end
    end

    assign period       = r_period;
    assign high_time    = r_high;
    assign period_valid = r_valid;
    assign locked       = r_locked;
    assign lost         = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_monitor
// Description : Self-checking bench for clk_period_monitor. An edge-timestamp
//               model predicts every output each cycle; directed waveforms
//               add literal checks for the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_monitor;

    localparam int c_WIDTH   = 16;
    localparam int c_TIMEOUT = 100;
    localparam int c_LOCK    = 4;
    localparam int c_TOL     = 1;

    logic               clk    = 1'b0;
    logic               rst    = 1'b0;
    logic               clk_in = 1'b0;
    logic [c_WIDTH-1:0] period;
    logic [c_WIDTH-1:0] high_time;
    logic               period_valid;
    logic               locked;
    logic               lost;

    int total      = 0;
    int bad        = 0;
    int valid_seen = 0;

    // Model state: edge timestamps in clk cycles
    int cyc        = 0;
    int last_rise  = 0;
    int run        = 0;
    int mode       = 0;   // 0 waiting for first edge, 1 timing, 2 lost
    int exp_period = 0;
    int exp_high   = 0;
    int exp_valid  = 0;
    int exp_locked = 0;
    int exp_lost   = 0;
    bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;   // clk_in sampled 1, 2, 3 edges ago

    clk_period_monitor #(
        .WIDTH      (c_WIDTH),
        .TIMEOUT    (c_TIMEOUT),
        .LOCK_COUNT (c_LOCK),
        .TOLERANCE  (c_TOL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_in       (clk_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // hi cycles high then lo cycles low, n times, starting at a negedge
    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            clk_in = 1'b1;
            repeat (hi) @(negedge clk);
            clk_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    // Model and per-cycle comparison
    initial begin : model
        bit r, f;
        int p, d;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mode = 0; run = 0; last_rise = 0;
                exp_period = 0; exp_high = 0; exp_valid = 0;
                exp_locked = 0; exp_lost = 0;
                h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            end else begin
                // An edge on clk_in takes effect two sampling edges after it is sampled
                r = h2 && !h3;
                f = !h2 && h3;
                exp_valid = 0;
                if (r) begin
                    if (mode == 1) begin
                        p = cyc - last_rise;
                        d = p - exp_period;
                        if (d < 0) d = -d;
                        if (run == 0 || d > c_TOL) run = 1;
                        else run++;
                        exp_period = p;
                        exp_valid  = 1;
                        exp_locked = (run >= c_LOCK) ? 1 : 0;
                    end else begin
                        mode     = 1;
                        run      = 0;
                        exp_lost = 0;
                    end
                    last_rise = cyc;
                end else if (mode == 1) begin
                    if (f) exp_high = cyc - last_rise;
                    if (cyc - last_rise == c_TIMEOUT) begin
                        mode = 2; exp_lost = 1; exp_locked = 0; run = 0;
                    end
                end
                h3 = h2; h2 = h1; h1 = clk_in;
            end
            #1;
            check("period",       int'(period),       exp_period);
            check("high_time",    int'(high_time),    exp_high);
            check("period_valid", int'(period_valid), exp_valid);
            check("locked",       int'(locked),       exp_locked);
            check("lost",         int'(lost),         exp_lost);
            if (period_valid) valid_seen++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not complete, got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_period",    int'(period),       0);
        check("rst_high",      int'(high_time),    0);
        check("rst_valid",     int'(period_valid), 0);
        check("rst_locked",    int'(locked),       0);
        check("rst_lost",      int'(lost),         0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: clk/12, 50% duty
        wave(6, 6, 5);
        check("t1_period", int'(period),    12);
        check("t1_high",   int'(high_time), 6);
        check("t1_locked", int'(locked),    1);
        v = valid_seen;
        wave(6, 6, 3);
        check("t1_valid_rate", valid_seen - v, 3);

        // 2: clk/5 with 3/2 duty, then +-1 jitter
        wave(3, 2, 5);
        check("t2_locked_first", int'(locked), 1);
        wave(3, 3, 1);
        wave(3, 2, 1);
        wave(2, 2, 1);
        wave(3, 2, 2);
        check("t2_period", int'(period),    5);
        check("t2_high",   int'(high_time), 3);
        check("t2_locked", int'(locked),    1);

        // 3: relock at 12, one period of 20, relock after 4 periods of 12
        wave(6, 6, 6);
        check("t3_locked_12", int'(locked), 1);
        wave(10, 10, 1);
        wave(6, 6, 1);
        check("t3_period_20", int'(period), 20);
        check("t3_unlocked",  int'(locked), 0);
        wave(6, 6, 3);
        check("t3_not_yet",   int'(locked), 0);
        wave(6, 6, 1);
        check("t3_relocked",  int'(locked), 1);

        // 4: clk_in stops low
        repeat (120) @(negedge clk);
        check("t4_lost",        int'(lost),      1);
        check("t4_locked",      int'(locked),    0);
        check("t4_period_hold", int'(period),    12);
        check("t4_high_hold",   int'(high_time), 6);
        v = valid_seen;
        wave(6, 6, 1);
        check("t4_lost_clear", int'(lost),     0);
        check("t4_no_valid",   valid_seen - v, 0);

        // 5: reset pulse while locked
        wave(6, 6, 5);
        check("t5_locked", int'(locked), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_period", int'(period),       0);
        check("t5_high",   int'(high_time),    0);
        check("t5_valid",  int'(period_valid), 0);
        check("t5_locked0",int'(locked),       0);
        check("t5_lost",   int'(lost),         0);
        @(negedge clk);
        rst = 1'b0;
        v = valid_seen;
        wave(6, 6, 1);
        check("t5_first_rise_no_valid", valid_seen - v, 0);
        check("t5_period_still0",       int'(period),   0);
        wave(6, 6, 1);
        check("t5_second_rise_valid", valid_seen - v, 1);
        check("t5_period_12",         int'(period),   12);

        // 6: rise lands on the timeout cycle
        wave(50, 50, 3);
        check("t6_period", int'(period), 100);
        check("t6_no_lost", int'(lost),  0);
        repeat (10) @(negedge clk);
        check("t6_lost_after", int'(lost), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
